text_video_gen: RTL



---
 rtl/vt52_video_pkg.sv | 29 ++
 rtl/text_video_timing.sv | 77 +++++++
 rtl/text_video_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vt52_video_pkg.sv
// Shared constants and helpers for the VT52 text-mode video generator:
// attribute bit positions, glyph geometry and CRTC timing arithmetic.
package vt52_video_pkg;

    localparam int GLYPH_W      = 8;
    localparam int GLYPH_W_LOG2 = 3;

    localparam int ATTR_REVERSE   = 0;
    localparam int ATTR_UNDERLINE = 1;
    localparam int ATTR_BLINK     = 2;
    localparam int ATTR_BRIGHT    = 3;

    // Sync/blank bundle carried through the latency-matching delay line.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
    } sync_t;

    function automatic int timing_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int text_voff(input int v_vis, input int rows, input int char_h_log2);
        return (v_vis - rows * (1 << char_h_log2)) / 2;
    endfunction

endpackage

// File: rtl/text_video_timing.sv
// Raster counters for the text generator: hc/vc, raw sync and blank
// decoded from the counters, and a one-clock frame_start at the (0,0) wrap.
module text_video_timing
    import vt52_video_pkg::*;
#(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int HC_BITS  = $clog2(timing_total(H_VIS, H_FP, H_SYNC, H_BP)),
    parameter int VC_BITS  = $clog2(timing_total(V_VIS, V_FP, V_SYNC, V_BP))
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce_pixel,
    output logic [HC_BITS-1:0] hc,
    output logic [VC_BITS-1:0] vc,
    output logic               hsync,
    output logic               vsync,
    output logic               hblank,
    output logic               vblank,
    output logic               frame_start
);
    localparam int   H_TOTAL     = timing_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int   V_TOTAL     = timing_total(V_VIS, V_FP, V_SYNC, V_BP);
    localparam int   HS_START    = H_VIS + H_FP;
    localparam int   HS_END      = HS_START + H_SYNC;
    localparam int   VS_START    = V_VIS + V_FP;
    localparam int   VS_END      = VS_START + V_SYNC;
    localparam logic SYNC_ACTIVE = (SYNC_POL != 0);

    logic [HC_BITS-1:0] hc_reg;
    logic [VC_BITS-1:0] vc_reg;
    logic               frame_start_reg;
    logic               h_last;
    logic               v_last;

    assign h_last = (hc_reg == HC_BITS'(H_TOTAL - 1));
    assign v_last = (vc_reg == VC_BITS'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hc_reg          <= '0;
            vc_reg          <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            if (ce_pixel) begin
                if (h_last) begin
                    hc_reg <= '0;
                    if (v_last) begin
                        vc_reg          <= '0;
                        frame_start_reg <= 1'b1;
                    end else begin
                        vc_reg <= vc_reg + 1'b1;
                    end
                end else begin
                    hc_reg <= hc_reg + 1'b1;
                end
            end
        end
    end

    assign hc          = hc_reg;
    assign vc          = vc_reg;
    assign frame_start = frame_start_reg;
    assign hblank      = (hc_reg >= HC_BITS'(H_VIS));
    assign vblank      = (vc_reg >= VC_BITS'(V_VIS));
    assign hsync = ((hc_reg >= HC_BITS'(HS_START)) && (hc_reg < HC_BITS'(HS_END))) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vsync = ((vc_reg >= VC_BITS'(VS_START)) && (vc_reg < VC_BITS'(VS_END))) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

endmodule

// File: rtl/text_video_gen.sv
// Text-mode raster generator: two-stage char-buffer / font-ROM fetch with
// hardware scroll, per-character attributes, blink timebase and cursor overlay.
module text_video_gen
    import vt52_video_pkg::*;
#(
    parameter int ROWS        = 24,
    parameter int COLS        = 80,
    parameter int ROW_BITS    = 5,
    parameter int COL_BITS    = 7,
    parameter int ADDR_BITS   = 11,
    parameter int CHAR_H_LOG2 = 4,
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_POL    = 0,
    parameter int BLINK_LOG2  = 5
)(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ce_pixel,
    input  logic [COL_BITS-1:0]         cursor_x,
    input  logic [ROW_BITS-1:0]         cursor_y,
    input  logic                        cursor_enable,
    input  logic                        cursor_underline,
    input  logic [ROW_BITS-1:0]         scroll_row,
    output logic [ADDR_BITS-1:0]        char_buffer_address,
    input  logic [15:0]                 char_buffer_data,
    output logic [8+CHAR_H_LOG2-1:0]    char_rom_address,
    input  logic [7:0]                  char_rom_data,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        hblank,
    output logic                        vblank,
    output logic                        video,
    output logic                        bright,
    output logic                        frame_start
);
    localparam int   HC_BITS     = $clog2(timing_total(H_VIS, H_FP, H_SYNC, H_BP));
    localparam int   VC_BITS     = $clog2(timing_total(V_VIS, V_FP, V_SYNC, V_BP));
    localparam int   VOFF        = text_voff(V_VIS, ROWS, CHAR_H_LOG2);
    localparam int   TEXT_LINES  = ROWS << CHAR_H_LOG2;
    localparam int   WIN_W       = (COLS * GLYPH_W < H_VIS) ? COLS * GLYPH_W : H_VIS;
    localparam logic SYNC_ACTIVE = (SYNC_POL != 0);
    localparam sync_t SYNC_IDLE  = '{hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE, hblank: 1'b1, vblank: 1'b1};
    localparam logic [CHAR_H_LOG2-1:0] LAST_LINE = CHAR_H_LOG2'((1 << CHAR_H_LOG2) - 1);
    localparam logic [CHAR_H_LOG2-1:0] UL_LINE   = CHAR_H_LOG2'((1 << CHAR_H_LOG2) - 2);

    logic [HC_BITS-1:0] hc;
    logic [VC_BITS-1:0] vc;
    sync_t              sync_raw;

    text_video_timing #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .HC_BITS(HC_BITS), .VC_BITS(VC_BITS)
    ) u_timing (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce_pixel    (ce_pixel),
        .hc          (hc),
        .vc          (vc),
        .hsync       (sync_raw.hsync),
        .vsync       (sync_raw.vsync),
        .hblank      (sync_raw.hblank),
        .vblank      (sync_raw.vblank),
        .frame_start (frame_start)
    );

    // Blink timebase and scroll offset both change only at frame_start.
    logic [BLINK_LOG2:0]   frame_cnt_reg;
    logic [ROW_BITS-1:0]   scroll_latch_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt_reg    <= '0;
            scroll_latch_reg <= '0;
        end else if (frame_start) begin
            frame_cnt_reg    <= frame_cnt_reg + 1'b1;
            scroll_latch_reg <= ({1'b0, scroll_row} < (ROW_BITS+1)'(ROWS)) ? scroll_row : '0;
        end
    end

    // S0: decode raster position into text coordinates and buffer address.
    logic [VC_BITS:0]         line_off;
    logic                     in_window;
    logic [ROW_BITS-1:0]      screen_row;
    logic [COL_BITS-1:0]      col;
    logic [CHAR_H_LOG2-1:0]   scanline;
    logic [ROW_BITS:0]        row_sum;
    logic [ROW_BITS-1:0]      phys_row;

    assign line_off   = {1'b0, vc} - (VC_BITS+1)'(VOFF);
    assign in_window  = !line_off[VC_BITS] && (line_off < (VC_BITS+1)'(TEXT_LINES))
                        && (hc < HC_BITS'(WIN_W));
    assign screen_row = line_off[CHAR_H_LOG2 +: ROW_BITS];
    assign scanline   = line_off[CHAR_H_LOG2-1:0];
    assign col        = hc[GLYPH_W_LOG2 +: COL_BITS];
    assign row_sum    = {1'b0, screen_row} + {1'b0, scroll_latch_reg};
    assign phys_row   = (row_sum >= (ROW_BITS+1)'(ROWS)) ? ROW_BITS'(row_sum - (ROW_BITS+1)'(ROWS))
                                                         : row_sum[ROW_BITS-1:0];
    assign char_buffer_address = ADDR_BITS'(int'(phys_row) * COLS + int'(col));

    // S1: buffer word plus the coordinates the composition stage still needs.
    logic [7:0]             s1_char_reg;
    logic [3:0]             s1_attr_reg;
    logic [CHAR_H_LOG2-1:0] s1_scanline_reg;
    logic [2:0]             s1_px_reg;
    logic [ROW_BITS-1:0]    s1_row_reg;
    logic [COL_BITS-1:0]    s1_col_reg;
    logic                   s1_in_window_reg;
    sync_t                  s1_sync_reg;
    logic                   unused_attr;

    assign unused_attr = ^char_buffer_data[15:12];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_char_reg      <= '0;
            s1_attr_reg      <= '0;
            s1_scanline_reg  <= '0;
            s1_px_reg        <= '0;
            s1_row_reg       <= '0;
            s1_col_reg       <= '0;
            s1_in_window_reg <= 1'b0;
            s1_sync_reg      <= SYNC_IDLE;
        end else if (ce_pixel) begin
            s1_char_reg      <= char_buffer_data[7:0];
            s1_attr_reg      <= char_buffer_data[11:8];
            s1_scanline_reg  <= scanline;
            s1_px_reg        <= hc[2:0];
            s1_row_reg       <= screen_row;
            s1_col_reg       <= col;
            s1_in_window_reg <= in_window;
            s1_sync_reg      <= sync_raw;
        end
    end

    assign char_rom_address = {s1_char_reg, s1_scanline_reg};

    // Composition order matters: underline, blink, reverse, then cursor inversion.
    logic pix_next;
    logic cursor_hit;

    always_comb begin
        pix_next   = char_rom_data[~s1_px_reg];
        cursor_hit = cursor_enable && frame_cnt_reg[BLINK_LOG2-1]
                     && (s1_row_reg == cursor_y) && (s1_col_reg == cursor_x)
                     && (!cursor_underline || (s1_scanline_reg >= UL_LINE));
        if (s1_attr_reg[ATTR_UNDERLINE] && (s1_scanline_reg == LAST_LINE))
            pix_next = 1'b1;
        if (s1_attr_reg[ATTR_BLINK] && !frame_cnt_reg[BLINK_LOG2])
            pix_next = 1'b0;
        pix_next = pix_next ^ s1_attr_reg[ATTR_REVERSE];
        if (cursor_hit)
            pix_next = ~pix_next;
    end

    // S2: output registers.
    logic  video_reg;
    logic  bright_reg;
    sync_t s2_sync_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            video_reg   <= 1'b0;
            bright_reg  <= 1'b0;
            s2_sync_reg <= SYNC_IDLE;
        end else if (ce_pixel) begin
            video_reg   <= pix_next & s1_in_window_reg;
            bright_reg  <= s1_attr_reg[ATTR_BRIGHT] & s1_in_window_reg;
            s2_sync_reg <= s1_sync_reg;
        end
    end

    assign video  = video_reg;
    assign bright = bright_reg;
    assign hsync  = s2_sync_reg.hsync;
    assign vsync  = s2_sync_reg.vsync;
    assign hblank = s2_sync_reg.hblank;
    assign vblank = s2_sync_reg.vblank;

endmodule
